// File: rtl/plug_pkg.sv
// Shared types and helpers for the Enigma plugboard engine.
// Letter codes 0..25 are A..Z; anything wider passes through untouched.
package plug_pkg;

   localparam int ALPHA = 26;
   localparam int LET_W = 5;

   typedef logic [LET_W-1:0] let_t;

   typedef logic [ALPHA-1:0][LET_W-1:0] map_t;

   typedef struct packed {
      logic act;
      let_t a;
      let_t b;
   } plug_slot_t;

   typedef enum logic [1:0] {
      IDLE,
      CHECK,
      COMMIT
   } cfg_state_t;

   function automatic map_t identity_map();
      map_t m;
      for (int i = 0; i < ALPHA; i++) begin
         m[i] = LET_W'(i);
      end
      return m;
   endfunction

   function automatic let_t map_lookup(input map_t m, input let_t x);
      let_t r;
      if (int'(x) >= ALPHA) begin
         r = x;
      end else begin
         r = m[x];
      end
      return r;
   endfunction

endpackage

// File: rtl/plug_conflict_check.sv
// Validates a pending slot request against the currently active slots.
// Pure combinational; the slot being rewritten may reuse its own letters.
module plug_conflict_check
   import plug_pkg::*;
#(
   parameter int NUM_PAIRS = 10,
   parameter int IDX_W     = 4
)(
   input  plug_slot_t [NUM_PAIRS-1:0] i_slots,
   input  logic [IDX_W-1:0]           i_idx,
   input  logic                       i_en,
   input  let_t                       i_a,
   input  let_t                       i_b,
   output logic                       o_err
);

   logic w_used;
   logic w_bad_idx;
   logic w_bad_let;

   always_comb begin
      w_used = 1'b0;
      for (int i = 0; i < NUM_PAIRS; i++) begin
         if (i_slots[i].act && (IDX_W'(i) != i_idx)) begin
            if ((i_slots[i].a == i_a) || (i_slots[i].b == i_a) ||
                (i_slots[i].a == i_b) || (i_slots[i].b == i_b)) begin
               w_used = 1'b1;
            end
         end
      end
   end

   assign w_bad_idx = (int'(i_idx) >= NUM_PAIRS);
   assign w_bad_let = (int'(i_a) >= ALPHA) || (int'(i_b) >= ALPHA) ||
                      (i_a == i_b) || w_used;
   assign o_err     = w_bad_idx || (i_en && w_bad_let);

endmodule

// File: rtl/plug_board_engine.sv
// Runtime-programmable Enigma plugboard: handshaked slot config plus
// a one-cycle forward/inverse letter lookup pipeline.
module plug_board_engine
   import plug_pkg::*;
#(
   parameter int NUM_PAIRS = 10,
   parameter int IDX_W     = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1,
   parameter int CNT_W     = $clog2(NUM_PAIRS + 1)
)(
   input  logic             CLK,
   input  logic             RST,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [IDX_W-1:0] cfg_idx,
   input  logic             cfg_en,
   input  logic [LET_W-1:0] cfg_a,
   input  logic [LET_W-1:0] cfg_b,
   output logic             cfg_done,
   output logic             cfg_err,
   output logic [CNT_W-1:0] plug_cnt,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [LET_W-1:0] in_let,
   input  logic [LET_W-1:0] in_let_inv,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [LET_W-1:0] out_let,
   output logic [LET_W-1:0] out_let_inv
);

   cfg_state_t                 r_state;
   map_t                       r_map;
   plug_slot_t [NUM_PAIRS-1:0] r_slots;
   logic [IDX_W-1:0]           r_idx;
   logic                       r_en;
   let_t                       r_a;
   let_t                       r_b;
   logic                       r_err;
   logic [CNT_W-1:0]           r_cnt;
   logic                       r_done;
   logic                       r_cfg_err;
   logic                       r_out_valid;
   let_t                       r_out_let;
   let_t                       r_out_let_inv;

   logic       w_cfg_acc;
   logic       w_in_acc;
   logic       w_err;
   plug_slot_t w_cur;

   assign cfg_ready = (r_state == IDLE);
   assign in_ready  = (r_state == IDLE) && (!r_out_valid || out_ready);
   assign w_cfg_acc = cfg_valid && cfg_ready;
   assign w_in_acc  = in_valid && in_ready;

   assign cfg_done    = r_done;
   assign cfg_err     = r_cfg_err;
   assign plug_cnt    = r_cnt;
   assign out_valid   = r_out_valid;
   assign out_let     = r_out_let;
   assign out_let_inv = r_out_let_inv;

   // Slot being rewritten; an out-of-range index reads as an idle slot.
   always_comb begin
      w_cur = '0;
      if (int'(r_idx) < NUM_PAIRS) begin
         w_cur = r_slots[r_idx];
      end
   end

   plug_conflict_check #(
      .NUM_PAIRS (NUM_PAIRS),
      .IDX_W     (IDX_W)
   ) u_check (
      .i_slots (r_slots),
      .i_idx   (r_idx),
      .i_en    (r_en),
      .i_a     (r_a),
      .i_b     (r_b),
      .o_err   (w_err)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state   <= IDLE;
         r_map     <= identity_map();
         r_slots   <= '0;
         r_idx     <= '0;
         r_en      <= 1'b0;
         r_a       <= '0;
         r_b       <= '0;
         r_err     <= 1'b0;
         r_cnt     <= '0;
         r_done    <= 1'b0;
         r_cfg_err <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (w_cfg_acc) begin
                  r_idx   <= cfg_idx;
                  r_en    <= cfg_en;
                  r_a     <= cfg_a;
                  r_b     <= cfg_b;
                  r_state <= CHECK;
               end
            end
            CHECK: begin
               r_err   <= w_err;
               r_state <= COMMIT;
            end
            COMMIT: begin
               if (!r_err) begin
                  // Plug writes come last so they win over the restore.
                  if (w_cur.act) begin
                     r_map[w_cur.a] <= w_cur.a;
                     r_map[w_cur.b] <= w_cur.b;
                  end
                  if (r_en) begin
                     r_map[r_a]     <= r_b;
                     r_map[r_b]     <= r_a;
                     r_slots[r_idx] <= '{act: 1'b1, a: r_a, b: r_b};
                  end else begin
                     r_slots[r_idx].act <= 1'b0;
                  end
                  if (w_cur.act && !r_en) begin
                     r_cnt <= r_cnt - CNT_W'(1);
                  end else if (!w_cur.act && r_en) begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               r_done    <= 1'b1;
               r_cfg_err <= r_err;
               r_state   <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_out_valid   <= 1'b0;
         r_out_let     <= '0;
         r_out_let_inv <= '0;
      end else if (w_in_acc) begin
         r_out_valid   <= 1'b1;
         r_out_let     <= map_lookup(r_map, in_let);
         r_out_let_inv <= map_lookup(r_map, in_let_inv);
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_plug_board_engine.sv
// Directed self-checking bench for plug_board_engine.
// Inputs change and outputs are sampled on the falling edge.
module tb_plug_board_engine;

   localparam int NP = 10;

   logic       CLK = 1'b0;
   logic       RST;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [3:0] cfg_idx;
   logic       cfg_en;
   logic [4:0] cfg_a;
   logic [4:0] cfg_b;
   logic       cfg_done;
   logic       cfg_err;
   logic [3:0] plug_cnt;
   logic       in_valid;
   logic       in_ready;
   logic [4:0] in_let;
   logic [4:0] in_let_inv;
   logic       out_valid;
   logic       out_ready;
   logic [4:0] out_let;
   logic [4:0] out_let_inv;

   int errors = 0;
   int checks = 0;

   int mdl[26];
   bit s_act[NP];
   int s_a[NP];
   int s_b[NP];

   always #5 CLK = ~CLK;

   plug_board_engine #(.NUM_PAIRS(NP)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_idx     (cfg_idx),
      .cfg_en      (cfg_en),
      .cfg_a       (cfg_a),
      .cfg_b       (cfg_b),
      .cfg_done    (cfg_done),
      .cfg_err     (cfg_err),
      .plug_cnt    (plug_cnt),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_let      (in_let),
      .in_let_inv  (in_let_inv),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_let     (out_let),
      .out_let_inv (out_let_inv)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 26; i++) mdl[i] = i;
      for (int i = 0; i < NP; i++) s_act[i] = 1'b0;
   endtask

   task automatic model_update(input int idx, input int en,
                               input int a, input int b);
      if (s_act[idx]) begin
         mdl[s_a[idx]] = s_a[idx];
         mdl[s_b[idx]] = s_b[idx];
      end
      if (en != 0) begin
         mdl[a] = b;
         mdl[b] = a;
         s_act[idx] = 1'b1;
         s_a[idx] = a;
         s_b[idx] = b;
      end else begin
         s_act[idx] = 1'b0;
      end
   endtask

   task automatic cfg(input int idx, input int en, input int a,
                      input int b, input bit exp_err, input string tag);
      @(negedge CLK);
      chk({tag, "_rdy"}, cfg_ready, 1);
      cfg_valid = 1'b1;
      cfg_idx = 4'(idx);
      cfg_en = en[0];
      cfg_a = 5'(a);
      cfg_b = 5'(b);
      @(negedge CLK);
      cfg_valid = 1'b0;
      chk({tag, "_check"}, {in_ready, cfg_done}, 0);
      @(negedge CLK);
      chk({tag, "_commit"}, {in_ready, cfg_done}, 0);
      @(negedge CLK);
      chk({tag, "_done"}, cfg_done, 1);
      chk({tag, "_err"}, cfg_err, exp_err);
      if (!exp_err) model_update(idx, en, a, b);
   endtask

   task automatic beat(input int l, input int li, input int el,
                       input int eli, input string tag);
      @(negedge CLK);
      in_valid = 1'b1;
      in_let = 5'(l);
      in_let_inv = 5'(li);
      out_ready = 1'b1;
      @(negedge CLK);
      in_valid = 1'b0;
      chk({tag, "_ov"}, out_valid, 1);
      chk({tag, "_let"}, out_let, el);
      chk({tag, "_inv"}, out_let_inv, eli);
   endtask

   task automatic check_map(input string tag);
      for (int x = 0; x < 26; x++) begin
         beat(x, mdl[x], mdl[x], x, tag);
      end
   endtask

   function automatic bit used(input int x);
      return mdl[x] != x;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int a;
      int b;
      RST = 1'b1;
      cfg_valid = 1'b0;
      cfg_idx = '0;
      cfg_en = 1'b0;
      cfg_a = '0;
      cfg_b = '0;
      in_valid = 1'b0;
      in_let = '0;
      in_let_inv = '0;
      out_ready = 1'b1;
      model_reset();

      repeat (2) @(negedge CLK);
      chk("rst_ov", out_valid, 0);
      chk("rst_let", out_let, 0);
      chk("rst_inv", out_let_inv, 0);
      chk("rst_cnt", plug_cnt, 0);
      chk("rst_done", cfg_done, 0);
      chk("rst_err", cfg_err, 0);
      RST = 1'b0;
      @(negedge CLK);
      chk("rst_cfg_rdy", cfg_ready, 1);
      chk("rst_in_rdy", in_ready, 1);

      beat(0, 25, 0, 25, "id_az");
      chk("id_cnt", plug_cnt, 0);

      cfg(0, 1, 0, 1, 1'b0, "plug_ab");
      chk("ab_cnt", plug_cnt, 1);
      beat(0, 1, 1, 0, "ab_map");

      cfg(1, 1, 1, 2, 1'b1, "plug_bc");
      beat(2, 2, 2, 2, "bc_c");
      chk("bc_cnt", plug_cnt, 1);
      cfg(1, 1, 2, 2, 1'b1, "plug_cc");
      cfg(1, 1, 2, 26, 1'b1, "plug_c26");
      cfg(10, 1, 5, 6, 1'b1, "bad_idx");
      beat(27, 31, 27, 31, "oob_pass");

      cfg(0, 1, 0, 3, 1'b0, "replug_ad");
      beat(0, 3, 3, 0, "ad_map");
      beat(1, 1, 1, 1, "ad_b");
      chk("ad_cnt", plug_cnt, 1);
      cfg(0, 1, 0, 3, 1'b0, "same_ad");
      beat(0, 3, 3, 0, "same_map");
      chk("same_cnt", plug_cnt, 1);
      cfg(0, 0, 0, 0, 1'b0, "unplug0");
      chk("unplug_cnt", plug_cnt, 0);
      check_map("unplug_id");
      cfg(0, 0, 0, 0, 1'b0, "unplug_idle");
      chk("unplug_idle_cnt", plug_cnt, 0);

      @(negedge CLK);
      in_valid = 1'b1;
      in_let = 5'd2;
      in_let_inv = 5'd3;
      out_ready = 1'b0;
      @(negedge CLK);
      in_let = 5'd7;
      in_let_inv = 5'd8;
      for (int c = 0; c < 5; c++) begin
         chk("hold_ov", out_valid, 1);
         chk("hold_let", out_let, 2);
         chk("hold_inv", out_let_inv, 3);
         chk("hold_rdy", in_ready, 0);
         @(negedge CLK);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge CLK);
      chk("hold_drain", out_valid, 0);

      @(negedge CLK);
      chk("sc_cfg_rdy", cfg_ready, 1);
      chk("sc_in_rdy", in_ready, 1);
      cfg_valid = 1'b1;
      cfg_idx = 4'd2;
      cfg_en = 1'b1;
      cfg_a = 5'd4;
      cfg_b = 5'd5;
      in_valid = 1'b1;
      in_let = 5'd4;
      in_let_inv = 5'd5;
      @(negedge CLK);
      cfg_valid = 1'b0;
      chk("sc_old_ov", out_valid, 1);
      chk("sc_old_let", out_let, 4);
      chk("sc_old_inv", out_let_inv, 5);
      chk("sc_check_rdy", in_ready, 0);
      @(negedge CLK);
      chk("sc_commit_rdy", in_ready, 0);
      chk("sc_commit_ov", out_valid, 0);
      @(negedge CLK);
      chk("sc_done", cfg_done, 1);
      chk("sc_err", cfg_err, 0);
      chk("sc_idle_rdy", in_ready, 1);
      model_update(2, 1, 4, 5);
      @(negedge CLK);
      in_valid = 1'b0;
      chk("sc_new_let", out_let, 5);
      chk("sc_new_inv", out_let_inv, 4);
      chk("sc_cnt", plug_cnt, 1);
      cfg(2, 0, 0, 0, 1'b0, "sc_unplug");
      chk("sc_unplug_cnt", plug_cnt, 0);

      for (int s = 0; s < NP; s++) begin
         do a = int'($urandom_range(0, 25)); while (used(a));
         do b = int'($urandom_range(0, 25)); while (used(b) || b == a);
         cfg(s, 1, a, b, 1'b0, "fill");
         check_map("fill_inv");
         chk("fill_cnt", plug_cnt, s + 1);
      end

      @(negedge CLK);
      cfg_valid = 1'b1;
      cfg_idx = 4'd3;
      cfg_en = 1'b0;
      @(negedge CLK);
      cfg_valid = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      #1;
      chk("mid_rst_cnt", plug_cnt, 0);
      chk("mid_rst_rdy", cfg_ready, 1);
      @(negedge CLK);
      RST = 1'b0;
      model_reset();
      for (int c = 0; c < 4; c++) begin
         chk("mid_rst_done", cfg_done, 0);
         @(negedge CLK);
      end
      check_map("mid_rst_id");
      chk("mid_rst_cnt2", plug_cnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
